// File: rtl/vga_pkg.sv
// Shared types and elaboration helpers for the VGA frame reader.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fr_state_t;

  function automatic int frame_pixels(input int h_display, input int v_display);
    return h_display * v_display;
  endfunction

  // The frame_start flag sits directly above the colour bits.
  function automatic int frame_start_bit(input int rgb_size);
    return rgb_size;
  endfunction

endpackage

// File: rtl/vga_frame_reader_fifo.sv
// Show-ahead synchronous FIFO holding returned framebuffer pixels.
module vga_frame_reader_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: storage is not reset; count/empty guarantee stale entries are never presented.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-fetch controller: linear framebuffer reads into the line buffer source port.
// Optional double-buffer mode: define VGA_FRAME_READER_DBUF_EN.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RGB_SIZE  = 12,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int AW        = 19,
  parameter int DEPTH     = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable,
  input  logic [AW-1:0]       fb_base,
`ifdef VGA_FRAME_READER_DBUF_EN
  input  logic [AW-1:0]       fb_base_alt,
  input  logic                swap_req,
  output logic                fb_sel,
`endif
  output logic                mem_req,
  output logic [AW-1:0]       mem_addr,
  input  logic                mem_gnt,
  input  logic [RGB_SIZE-1:0] mem_rdata,
  input  logic                mem_rvld,
  output logic [RGB_SIZE:0]   line_buffer_data,
  output logic                line_buffer_vld,
  input  logic                line_buffer_rdy,
  output logic                busy,
  output logic                frame_done
);

  localparam int TOTAL = frame_pixels(H_DISPLAY, V_DISPLAY);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int OW    = $clog2(DEPTH + 1);
  localparam int SB    = frame_start_bit(RGB_SIZE);

  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);

  fr_state_t           state;
  logic [AW-1:0]       addr;
  logic [CW-1:0]       issue_cnt;
  logic [CW-1:0]       pix_cnt;
  logic [OW-1:0]       outstanding;
  logic [OW-1:0]       fifo_count;
  logic [RGB_SIZE-1:0] fifo_head;
  logic                fifo_empty;
  logic                fifo_full;
  logic                credit_ok;
  logic                start;
  logic                grant;
  logic                push;
  logic                pop;
  logic [AW-1:0]       start_base;

  // Credits cover both in-flight reads and buffered words, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (OW + 1)'(DEPTH);
  assign start     = (state == IDLE) && enable;
  assign mem_req   = (state == FETCH) && (issue_cnt < TOTAL_C) && credit_ok;
  assign mem_addr  = addr;
  assign grant     = mem_req && mem_gnt;
  assign push      = mem_rvld && (outstanding != '0) && !fifo_full;
  assign pop       = line_buffer_vld && line_buffer_rdy;

  assign line_buffer_vld = !fifo_empty;

  always_comb begin
    line_buffer_data = '0;
    if (!fifo_empty) begin
      line_buffer_data[SB]         = (pix_cnt == '0);
      line_buffer_data[SB-1:0]     = fifo_head;
    end
  end

`ifdef VGA_FRAME_READER_DBUF_EN
  logic swap_pending;
  logic next_sel;

  assign next_sel   = fb_sel ^ swap_pending;
  assign start_base = next_sel ? fb_base_alt : fb_base;

  // A swap request in the start cycle stays pending for the following frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fb_sel       <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (start) fb_sel <= next_sel;
      if (swap_req)   swap_pending <= 1'b1;
      else if (start) swap_pending <= 1'b0;
    end
  end
`else
  assign start_base = fb_base;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      addr       <= '0;
      issue_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            addr      <= start_base;
            issue_cnt <= '0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (grant) begin
            addr      <= addr + AW'(1);
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == LAST_C) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (pix_cnt == LAST_C)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pix_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (start)    pix_cnt <= '0;
      else if (pop) pix_cnt <= pix_cnt + CW'(1);
      case ({grant, push})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  vga_frame_reader_fifo #(
    .WIDTH (RGB_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a 4x2 frame with a latency-2 memory model.
module tb_vga_frame_reader;

  localparam int RGB   = 12;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int AW    = 19;
  localparam int DEPTH = 4;
  localparam int TOTAL = H * V;
  localparam int LAT   = 2;

  logic            sys_clk;
  logic            sys_rst;
  logic            enable;
  logic [AW-1:0]   fb_base;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_gnt;
  logic [RGB-1:0]  mem_rdata;
  logic            mem_rvld;
  logic [RGB:0]    line_buffer_data;
  logic            line_buffer_vld;
  logic            line_buffer_rdy;
  logic            busy;
  logic            frame_done;
`ifdef VGA_FRAME_READER_DBUF_EN
  logic [AW-1:0]   fb_base_alt;
  logic            swap_req;
  logic            fb_sel;
`endif

  vga_frame_reader #(
    .RGB_SIZE  (RGB),
    .H_DISPLAY (H),
    .V_DISPLAY (V),
    .AW        (AW),
    .DEPTH     (DEPTH)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .enable           (enable),
    .fb_base          (fb_base),
`ifdef VGA_FRAME_READER_DBUF_EN
    .fb_base_alt      (fb_base_alt),
    .swap_req         (swap_req),
    .fb_sel           (fb_sel),
`endif
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_gnt          (mem_gnt),
    .mem_rdata        (mem_rdata),
    .mem_rvld         (mem_rvld),
    .line_buffer_data (line_buffer_data),
    .line_buffer_vld  (line_buffer_vld),
    .line_buffer_rdy  (line_buffer_rdy),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int             due;
    logic [RGB-1:0] data;
  } ret_t;

  ret_t          rq[$];
  int            cyc = 0;
  int            issued = 0;
  int            accepted = 0;
  int            done_cnt = 0;
  logic          gnt_rand = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] fbase [4];
  logic          prev_req = 1'b0;
  logic          prev_gnt = 1'b0;
  logic          prev_rst = 1'b1;
  logic [AW-1:0] prev_addr = '0;

  // Memory and sink model: drive on the falling edge, observe the handshakes 1 ns later.
  always @(negedge sys_clk) begin
    logic [AW-1:0] ea;
    logic [AW-1:0] fb;
    logic [RGB:0]  ew;
    cyc++;
    mem_gnt         = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    line_buffer_rdy = !stall;
    mem_rvld        = 1'b0;
    mem_rdata       = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvld  = 1'b1;
      mem_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    #1;
    if (!sys_rst) begin
      if (prev_req && !prev_gnt && !prev_rst) begin
        check("req_hold", 32'(mem_req), 32'd1);
        check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      if (mem_req && mem_gnt) begin
        fb = fbase[(issued / TOTAL) % 4];
        ea = fb + AW'(issued % TOTAL);
        check("req_addr", 32'(mem_addr), 32'(ea));
        rq.push_back('{cyc + LAT, RGB'(mem_addr - fb)});
        issued++;
      end
      if (line_buffer_vld && line_buffer_rdy) begin
        ew = {(accepted % TOTAL) == 0, RGB'(accepted % TOTAL)};
        check("lb_word", 32'(line_buffer_data), 32'(ew));
        accepted++;
      end
      if (stall) check("credit_bound", 32'(issued - accepted <= DEPTH), 32'd1);
      if (frame_done) done_cnt++;
    end
    prev_req  = mem_req;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr;
    prev_rst  = sys_rst;
  end

  task automatic clear_counts();
    issued   = 0;
    accepted = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame();
    @(negedge sys_clk);
    enable = 1'b1;
    @(negedge sys_clk);
    enable = 1'b0;
    #2;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge sys_clk);
      #2;
      k++;
    end
    check("frame_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_accepted(input int target, input int budget);
    int k = 0;
    while (accepted < target && k < budget) begin
      @(negedge sys_clk);
      #2;
      k++;
    end
    check("accept_timeout", 32'(accepted >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   32'(mem_req), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_vld"},   32'(line_buffer_vld), 32'd0);
    check({tag, "_data"},  32'(line_buffer_data), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst         = 1'b1;
    enable          = 1'b0;
    fb_base         = '0;
    mem_gnt         = 1'b0;
    mem_rvld        = 1'b0;
    mem_rdata       = '0;
    line_buffer_rdy = 1'b0;
`ifdef VGA_FRAME_READER_DBUF_EN
    fb_base_alt     = '0;
    swap_req        = 1'b0;
`endif
    for (int i = 0; i < 4; i++) fbase[i] = '0;

    repeat (3) @(negedge sys_clk);
    #2;
    check_idle_outputs("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Single frame, full-rate grants and sink.
    clear_counts();
    fb_base  = 19'h00100;
    fbase[0] = 19'h00100;
    start_frame();
    check("first_req", 32'(mem_req), 32'd1);
    check("busy_start", 32'(busy), 32'd1);
    wait_frames(1, 100);
    check("done_pulse", 32'(frame_done), 32'd1);
    @(negedge sys_clk);
    #2;
    check("done_single", 32'(frame_done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("words_out", 32'(accepted), 32'(TOTAL));
    check("done_count", 32'(done_cnt), 32'd1);

    // Sink stalls mid-frame; base chosen so the address wraps.
    clear_counts();
    fb_base  = 19'h7FFFC;
    fbase[0] = 19'h7FFFC;
    start_frame();
    wait_accepted(2, 50);
    stall = 1'b1;
    repeat (20) @(negedge sys_clk);
    #2;
    check("stall_req_off", 32'(mem_req), 32'd0);
    check("stall_credits", 32'(issued - accepted), 32'(DEPTH));
    stall = 1'b0;
    wait_frames(1, 100);
    check("stall_words", 32'(accepted), 32'(TOTAL));

    // Random grants.
    clear_counts();
    gnt_rand = 1'b1;
    fb_base  = 19'h002A0;
    fbase[0] = 19'h002A0;
    start_frame();
    wait_frames(1, 300);
    check("rand_issued", 32'(issued), 32'(TOTAL));
    check("rand_words", 32'(accepted), 32'(TOTAL));
    gnt_rand = 1'b0;

    // Reset mid-frame with reads in flight, then restart.
    clear_counts();
    fb_base  = 19'h00040;
    fbase[0] = 19'h00040;
    start_frame();
    wait_accepted(3, 50);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    #2;
    check_idle_outputs("midrst");
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      #2;
      check("late_rvld_drop", 32'(line_buffer_vld), 32'd0);
    end
    clear_counts();
    start_frame();
    wait_frames(1, 100);
    check("restart_words", 32'(accepted), 32'(TOTAL));

    // Back-to-back frames with enable held.
    clear_counts();
    fb_base  = 19'h00500;
    fbase[0] = 19'h00500;
    fbase[1] = 19'h00500;
    @(negedge sys_clk);
    enable = 1'b1;
    wait_frames(1, 100);
    check("b2b_idle_busy", 32'(busy), 32'd0);
    @(negedge sys_clk);
    #2;
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_req", 32'(mem_req), 32'd1);
    wait_frames(2, 100);
    enable = 1'b0;
    check("b2b_words", 32'(accepted), 32'(2 * TOTAL));
    @(negedge sys_clk);
    #2;
    check("b2b_stop", 32'(busy), 32'd0);

`ifdef VGA_FRAME_READER_DBUF_EN
    // Double buffering: swap during frame 0 moves frames 1 and 2 to the alternate base.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #2;
    check("dbuf_sel_rst", 32'(fb_sel), 32'd0);
    clear_counts();
    fb_base     = 19'h01000;
    fb_base_alt = 19'h02000;
    fbase[0]    = 19'h01000;
    fbase[1]    = 19'h02000;
    fbase[2]    = 19'h02000;
    start_frame();
    @(negedge sys_clk);
    swap_req = 1'b1;
    @(negedge sys_clk);
    swap_req = 1'b0;
    wait_frames(1, 100);
    check("dbuf_sel_f0", 32'(fb_sel), 32'd0);
    start_frame();
    check("dbuf_sel_f1", 32'(fb_sel), 32'd1);
    wait_frames(2, 100);
    start_frame();
    check("dbuf_sel_f2", 32'(fb_sel), 32'd1);
    wait_frames(3, 100);
    check("dbuf_words", 32'(accepted), 32'(3 * TOTAL));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Frame-fetch controller on the sys_clk side of the VGA sync core.
- Sequences linear reads of one RGB frame from framebuffer memory and pushes {frame_start, rgb} words into the line buffer source port with a vld/rdy handshake.
- Bounds outstanding memory reads by the free space in an internal return FIFO, so line buffer backpressure never drops data.

Parameters:
- RGB_SIZE, 12, pixel colour width.
- H_DISPLAY, 640, active pixels per line.
- V_DISPLAY, 480, active lines per frame.
- AW, 19, framebuffer word address width.
- DEPTH, 4, return FIFO depth and maximum outstanding reads (power of 2, >=2).

Ports:
- sys_clk  in  1  system clock; the block's only clock.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  level; allows a new frame to start.
- fb_base  in  AW  frame base address; sampled at frame start.
- mem_req  out  1  read request.
- mem_addr  out  AW  read address; stable while mem_req=1 and mem_gnt=0.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  RGB_SIZE  read data.
- mem_rvld  in  1  read data valid; returns in request order, any latency >=1.
- line_buffer_data  out  RGB_SIZE+1  bit RGB_SIZE = frame_start, lower bits = rgb.
- line_buffer_vld  out  1  word valid.
- line_buffer_rdy  in  1  sink ready.
- busy  out  1  high from frame start until the last pixel is accepted by the sink.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Clock and reset: one clock (sys_clk); synchronous active-high reset (sys_rst).
- Reset values: all outputs 0; FIFO empty; counters 0; state IDLE.
- State IDLE:
  - enable=1 -> latch fb_base into addr; clear pix_cnt and issue_cnt; go to FETCH.
  - busy asserts on the following cycle.
- State FETCH:
  - mem_req=1 when issue_cnt < H_DISPLAY*V_DISPLAY and (outstanding + fifo_count) < DEPTH.
  - On mem_req & mem_gnt: addr += 1; issue_cnt += 1; outstanding += 1.
  - mem_req must not deassert while waiting for gnt, except on reset.
  - After the final grant -> DRAIN.
- State DRAIN:
  - Wait until the last pixel is accepted (line_buffer_vld & line_buffer_rdy with pix_cnt = total-1).
  - Pulse frame_done; go to IDLE.
  - Back-to-back frames: if enable is still 1, IDLE restarts on the next cycle, so there is one idle cycle between frames.
- Return path:
  - mem_rvld pushes mem_rdata into the FIFO; outstanding -= 1.
  - Simultaneous grant and rvld: outstanding unchanged.
- Output:
  - line_buffer_vld = !fifo_empty; data = {pix_cnt==0, fifo_head}.
  - Pop and pix_cnt += 1 on vld & rdy.
  - Data is held stable while vld & !rdy.
- Invariant: outstanding + fifo_count <= DEPTH, so the FIFO never overflows. An mem_rvld with outstanding=0 is a protocol error and is ignored.
- Widths and wrap:
  - addr wraps modulo 2^AW.
  - pix_cnt and issue_cnt are $clog2(H_DISPLAY*V_DISPLAY+1) bits.
- enable deasserted mid-frame: the current frame completes; only a new start is blocked.
- sys_rst mid-frame:
  - Everything clears immediately, including in-flight credits.
  - Memory returns after reset are discarded, because outstanding=0.
- Latency: first mem_req appears 1 cycle after the enable sample; the first line buffer word appears 1 cycle after the first mem_rvld.

Optional Feature:
- Macro: VGA_FRAME_READER_DBUF_EN.
- Defined (double-buffer mode):
  - Adds input fb_base_alt[AW-1:0], input swap_req (pulse), output fb_sel.
  - swap_req sets a pending flag.
  - At the next frame start, fb_sel toggles and the pending flag clears; that frame reads from fb_sel ? fb_base_alt : fb_base.
  - swap_req arriving the same cycle as a frame start applies to the following frame.
  - fb_sel resets to 0.
- Undefined: ports absent; fb_base is always used.

Decomposition:
- Package vga_pkg:
  - typedef enum {IDLE, FETCH, DRAIN} fr_state_t.
  - Localparam function for the frame pixel count.
  - Helper for the line_buffer_data packing bit index.
- Sub-module vga_frame_reader_fifo:
  - Synchronous FIFO, DEPTH x RGB_SIZE.
  - Outputs count, empty, full.
  - Show-ahead read.

Test Plan:
- H=4,V=2, mem_gnt=1, rvld latency 2, rdy=1 -> addresses base..base+7 issued.
  - 8 words out; first word has bit RGB_SIZE=1, the rest 0.
  - frame_done pulses once; busy drops the next cycle.
- line_buffer_rdy=0 for 20 cycles mid-frame -> at most DEPTH reads outstanding plus buffered; mem_req stalls; no data lost or reordered (check sequence 0..7 from a memory model holding addr-base).
- mem_gnt random 50% -> mem_addr is stable until gnt; no skipped or duplicate addresses.
- sys_rst asserted on pixel 3 with 2 reads outstanding -> all outputs 0 next cycle; late rvld ignored; a restarted frame begins at pixel 0 with frame_start=1.
- enable held high -> back-to-back frames with exactly 1 idle cycle; the second frame's first word flagged frame_start.
- DBUF_EN: swap_req during frame 0 -> frame 1 reads from fb_base_alt with fb_sel=1; no swap -> frame 2 stays on alt.
